mcs_mmio_bridge: RTL and testbench
==================================

MCS_MMIO_BRIDGE -- requirements
Module: mcs_mmio_bridge

Interface
REQ-001 SHALL have parameter BRIDGE_BASE, default 8'hC0, io_address[31:24] value that selects the MMIO window.
REQ-002 SHALL have parameter RD_LAT, default 1, range 0-3, extra hold cycles before mmio_rd_data capture.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 io_addr_strobe  in  1  MCS IO bus request valid.
REQ-006 io_read_strobe  in  1  read request qualifier.
REQ-007 io_write_strobe  in  1  write request qualifier.
REQ-008 io_address  in  32  MCS byte address.
REQ-009 io_byte_enable  in  4  MCS byte lanes; ignored, every write is full-word.
REQ-010 io_write_data  in  32  MCS write data.
REQ-011 io_read_data  out  32  read response data.
REQ-012 io_ready  out  1  one-cycle transfer-complete pulse.
REQ-013 mmio_cs  out  1  FPro bus select.
REQ-014 mmio_read  out  1  FPro read strobe.
REQ-015 mmio_write  out  1  FPro write strobe.
REQ-016 mmio_addr  out  21  FPro word address = io_address[22:2].
REQ-017 mmio_wr_data  out  32  FPro write data.
REQ-018 mmio_rd_data  in  32  FPro read data from the MMIO controller.
REQ-019 err_clr  in  1  clears the error capture.
REQ-020 err_valid  out  1  sticky decode/protocol error flag.
REQ-021 err_addr  out  32  io_address of the first captured error.

Function
REQ-022 SHALL implement FSM IDLE, ISSUE, WAIT, RESP.
REQ-023 IDLE: io_addr_strobe with a read or write strobe SHALL register address/data/direction and go to ISSUE; strobes seen outside IDLE SHALL be ignored.
REQ-024 In-window (io_address[31:24]==BRIDGE_BASE) ISSUE SHALL assert mmio_cs plus exactly one of mmio_read/mmio_write for one cycle.
REQ-025 Write: ISSUE->RESP; io_ready high the cycle after ISSUE (strobe cycle T, mmio_write T+1, io_ready T+2).
REQ-026 Read: mmio_cs and mmio_addr SHALL stay stable through RD_LAT WAIT cycles; mmio_read high in ISSUE only.
REQ-027 mmio_rd_data SHALL be captured at the end of the last ISSUE/WAIT cycle; io_ready the following cycle (RD_LAT=1: mmio_read T+1, capture T+2, io_ready T+3).
REQ-028 io_read_data SHALL hold the last captured value until the next read completes; writes leave it unchanged.
REQ-029 Out-of-window access SHALL produce no mmio activity, io_ready at T+2, io_read_data 32'h0 on reads.
REQ-030 Simultaneous read and write strobes: write SHALL take precedence; counted as protocol error.
REQ-031 RESP SHALL last one cycle and return to IDLE; a strobe in the RESP cycle is ignored.
REQ-032 mmio_cs/read/write SHALL be 0 in IDLE and RESP.

Reset
REQ-033 reset SHALL force IDLE; io_ready, mmio_cs, mmio_read, mmio_write, err_valid to 0; io_read_data, mmio_addr, mmio_wr_data, err_addr to 0.
REQ-034 reset mid-transfer SHALL abort without issuing io_ready or any further mmio strobe.

Configuration
REQ-035 Macro MCS_BRIDGE_ERR_EN defined: out-of-window or dual-strobe access SHALL set err_valid and load err_addr if err_valid was 0; err_clr clears both next cycle; err_clr and a new error in the same cycle -> error wins.
REQ-036 Macro undefined: err_valid and err_addr SHALL be constant 0, err_clr ignored, no capture logic synthesized.

Structure
REQ-037 Package mcs_bridge_pkg SHALL hold the FSM state enum, MMIO address width (21) and word-index slice constants.
REQ-038 Single module; no sub-module.

Verification
REQ-039 Write 0xC000_0014 data 0x1234_5678 -> mmio_write=1 one cycle, mmio_addr=5, mmio_wr_data=0x1234_5678, io_ready at T+2.
REQ-040 Read 0xC000_0008, RD_LAT=1, mmio_rd_data=0xA5A5_0001 -> mmio_read one cycle, addr=2 held 2 cycles, io_ready T+3, io_read_data=0xA5A5_0001.
REQ-041 Read 0x8000_0000 -> no mmio_cs, io_ready T+2, io_read_data=0; with MCS_BRIDGE_ERR_EN err_valid=1, err_addr=0x8000_0000.
REQ-042 Second strobe during WAIT -> ignored, exactly one io_ready.
REQ-043 reset asserted in WAIT -> no io_ready, all outputs 0 next cycle; next read completes normally.
REQ-044 err_clr coincident with new out-of-window access (macro on) -> err_valid stays 1, err_addr = new address.

Source files
------------

// File: rtl/mcs_bridge_pkg.sv
// Shared types and address-slice constants for the MCS IO bus to FPro MMIO bridge.
package mcs_bridge_pkg;

    localparam int unsigned MMIO_AW  = 21;
    localparam int unsigned WORD_LSB = 2;
    localparam int unsigned WORD_MSB = WORD_LSB + MMIO_AW - 1;
    localparam int unsigned WIN_LSB  = 24;
    localparam int unsigned WIN_MSB  = 31;
    localparam int unsigned WAIT_CW  = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } bridge_state_e;

    function automatic logic [MMIO_AW-1:0] word_index(input logic [31:0] addr);
        return addr[WORD_MSB:WORD_LSB];
    endfunction

endpackage

// File: rtl/mcs_mmio_bridge.sv
// Bridges MicroBlaze MCS IO bus transfers onto the FPro MMIO bus (one transfer at a time).
// Optional error capture is enabled by defining MCS_BRIDGE_ERR_EN.
module mcs_mmio_bridge
    import mcs_bridge_pkg::*;
#(
    parameter logic [7:0]  BRIDGE_BASE = 8'hC0,
    parameter int unsigned RD_LAT      = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               io_addr_strobe,
    input  logic               io_read_strobe,
    input  logic               io_write_strobe,
    input  logic [31:0]        io_address,
    input  logic [3:0]         io_byte_enable,
    input  logic [31:0]        io_write_data,
    output logic [31:0]        io_read_data,
    output logic               io_ready,
    output logic               mmio_cs,
    output logic               mmio_read,
    output logic               mmio_write,
    output logic [MMIO_AW-1:0] mmio_addr,
    output logic [31:0]        mmio_wr_data,
    input  logic [31:0]        mmio_rd_data,
    input  logic               err_clr,
    output logic               err_valid,
    output logic [31:0]        err_addr
);

    bridge_state_e      r_state;
    logic               r_is_wr;
    logic               r_in_win;
    logic [WAIT_CW-1:0] r_wait_cnt;

    logic w_req;
    logic w_in_win;
    logic w_dual;
    logic w_accept;

    assign w_req    = io_addr_strobe & (io_read_strobe | io_write_strobe);
    assign w_in_win = (io_address[WIN_MSB:WIN_LSB] == BRIDGE_BASE);
    assign w_dual   = io_read_strobe & io_write_strobe;
    assign w_accept = (r_state == ST_IDLE) & w_req;

    // Transfer sequencer; all bus strobes and the response are registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_is_wr      <= 1'b0;
            r_in_win     <= 1'b0;
            r_wait_cnt   <= '0;
            io_ready     <= 1'b0;
            io_read_data <= '0;
            mmio_cs      <= 1'b0;
            mmio_read    <= 1'b0;
            mmio_write   <= 1'b0;
            mmio_addr    <= '0;
            mmio_wr_data <= '0;
        end else begin
            io_ready   <= 1'b0;
            mmio_read  <= 1'b0;
            mmio_write <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_state  <= ST_ISSUE;
                        r_is_wr  <= io_write_strobe;
                        r_in_win <= w_in_win;
                        if (w_in_win) begin
                            mmio_cs      <= 1'b1;
                            mmio_read    <= ~io_write_strobe;
                            mmio_write   <= io_write_strobe;
                            mmio_addr    <= word_index(io_address);
                            mmio_wr_data <= io_write_data;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (r_in_win && !r_is_wr && (RD_LAT != 0)) begin
                        r_state    <= ST_WAIT;
                        r_wait_cnt <= WAIT_CW'(RD_LAT - 1);
                    end else begin
                        r_state  <= ST_RESP;
                        io_ready <= 1'b1;
                        mmio_cs  <= 1'b0;
                        if (!r_is_wr) begin
                            io_read_data <= r_in_win ? mmio_rd_data : 32'h0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_state      <= ST_RESP;
                        io_ready     <= 1'b1;
                        mmio_cs      <= 1'b0;
                        io_read_data <= mmio_rd_data;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - WAIT_CW'(1);
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    mmio_cs <= 1'b0;
                end
            endcase
        end
    end

`ifdef MCS_BRIDGE_ERR_EN
    logic w_err_event;
    assign w_err_event = w_accept & (~w_in_win | w_dual);

    // Sticky capture of the first bad access; a coincident clear lets the new error reload.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
        end else if (w_err_event) begin
            err_valid <= 1'b1;
            if (!err_valid || err_clr) begin
                err_addr <= io_address;
            end
        end else if (err_clr) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
        end
    end

    logic w_unused;
    assign w_unused = ^{io_byte_enable, io_address[WORD_LSB-1:0], io_address[WIN_LSB-1]};
`else
    assign err_valid = 1'b0;
    assign err_addr  = 32'h0;

    logic w_unused;
    assign w_unused = ^{io_byte_enable, io_address[WORD_LSB-1:0], io_address[WIN_LSB-1],
                        err_clr, w_accept, w_dual};
`endif

endmodule

// File: tb/tb_mcs_mmio_bridge.sv
// Scoreboard bench for mcs_mmio_bridge (default RD_LAT=1, BRIDGE_BASE=8'hC0).
module tb_mcs_mmio_bridge;

    localparam int unsigned RD_LAT = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_addr_strobe, io_read_strobe, io_write_strobe;
    logic [31:0] io_address, io_write_data, io_read_data;
    logic [3:0]  io_byte_enable;
    logic        io_ready, mmio_cs, mmio_read, mmio_write;
    logic [20:0] mmio_addr;
    logic [31:0] mmio_wr_data, mmio_rd_data;
    logic        err_clr, err_valid;
    logic [31:0] err_addr;

    always #5 clk = ~clk;

    mcs_mmio_bridge #(.BRIDGE_BASE(8'hC0), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset),
        .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
        .io_write_strobe(io_write_strobe), .io_address(io_address),
        .io_byte_enable(io_byte_enable), .io_write_data(io_write_data),
        .io_read_data(io_read_data), .io_ready(io_ready),
        .mmio_cs(mmio_cs), .mmio_read(mmio_read), .mmio_write(mmio_write),
        .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data), .mmio_rd_data(mmio_rd_data),
        .err_clr(err_clr), .err_valid(err_valid), .err_addr(err_addr)
    );

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        bit          is_rd;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_rd = 32'h0;
    logic        model_ev = 1'b0;
    logic [31:0] model_ea = 32'h0;

    task automatic check_err(input string name);
        logic        ev;
        logic [31:0] ea;
`ifdef MCS_BRIDGE_ERR_EN
        ev = model_ev;
        ea = model_ea;
`else
        ev = 1'b0;
        ea = 32'h0;
`endif
        n_checks++;
        if (err_valid !== ev) begin
            n_fail++;
            $display("FAIL %s err_valid got=%b exp=%b", name, err_valid, ev);
        end
        n_checks++;
        if (err_addr !== ea) begin
            n_fail++;
            $display("FAIL %s err_addr got=%h exp=%h", name, err_addr, ea);
        end
    endtask

    // One IO transfer; optional extra strobe in cycle extra_cyc after the request.
    task automatic access(input string name, input bit wr, input bit rd,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] bus_rdata, input int extra_cyc, input bit clr);
        logic [7:0]  win;
        logic [20:0] exp_addr;
        bit          in_win;
        int          exp_cs, cs_n, rd_n, wr_n, rdy_n;
        exp_t        e;
        win      = addr[31:24];
        exp_addr = addr[22:2];
        in_win   = (win == 8'hC0);
        exp_cs   = !in_win ? 0 : (wr ? 1 : 1 + RD_LAT);
        cs_n = 0; rd_n = 0; wr_n = 0; rdy_n = 0;

        @(posedge clk); #1;
        io_addr_strobe  = 1'b1;
        io_read_strobe  = rd;
        io_write_strobe = wr;
        io_address      = addr;
        io_write_data   = wdata;
        mmio_rd_data    = bus_rdata;
        err_clr         = clr;
        sb_q.push_back('{(in_win && !wr) ? 2 + RD_LAT : 2, in_win ? bus_rdata : 32'h0, !wr});
        if (!in_win || (wr && rd)) begin
            if (!model_ev || clr) model_ea = addr;
            model_ev = 1'b1;
        end else if (clr) begin
            model_ev = 1'b0;
            model_ea = 32'h0;
        end

        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(posedge clk); #1;
            err_clr = 1'b0;
            if (cyc == extra_cyc) begin
                io_addr_strobe = 1'b1; io_read_strobe = 1'b1; io_write_strobe = 1'b0;
                io_address = 32'hC000_0100;
            end else begin
                io_addr_strobe = 1'b0; io_read_strobe = 1'b0; io_write_strobe = 1'b0;
            end
            @(negedge clk);
            if (mmio_read)  rd_n++;
            if (mmio_write) wr_n++;
            if (mmio_cs) begin
                cs_n++;
                n_checks++;
                if (mmio_addr !== exp_addr) begin
                    n_fail++;
                    $display("FAIL %s mmio_addr cyc=%0d got=%h exp=%h", name, cyc, mmio_addr, exp_addr);
                end
                if (mmio_write) begin
                    n_checks++;
                    if (mmio_wr_data !== wdata) begin
                        n_fail++;
                        $display("FAIL %s mmio_wr_data got=%h exp=%h", name, mmio_wr_data, wdata);
                    end
                end
            end
            if (io_ready) begin
                rdy_n++;
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s spurious io_ready cyc=%0d", name, cyc);
                end else begin
                    e = sb_q.pop_front();
                    if (cyc !== e.lat) begin
                        n_fail++;
                        $display("FAIL %s ready_latency got=%0d exp=%0d", name, cyc, e.lat);
                    end
                    if (e.is_rd) begin
                        model_rd = e.rdata;
                        n_checks++;
                        if (io_read_data !== e.rdata) begin
                            n_fail++;
                            $display("FAIL %s io_read_data got=%h exp=%h", name, io_read_data, e.rdata);
                        end
                    end
                end
            end
        end

        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s ready_timeout pending=%0d exp=0", name, sb_q.size());
            sb_q.delete();
        end
        n_checks++;
        if (rdy_n != 1) begin
            n_fail++;
            $display("FAIL %s ready_count got=%0d exp=1", name, rdy_n);
        end
        n_checks++;
        if (cs_n != exp_cs) begin
            n_fail++;
            $display("FAIL %s cs_cycles got=%0d exp=%0d", name, cs_n, exp_cs);
        end
        n_checks++;
        if (wr_n != ((in_win && wr) ? 1 : 0) || rd_n != ((in_win && !wr) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL %s strobe_count rd=%0d wr=%0d exp_rd=%0d exp_wr=%0d", name, rd_n, wr_n,
                     (in_win && !wr) ? 1 : 0, (in_win && wr) ? 1 : 0);
        end
        n_checks++;
        if (io_read_data !== model_rd) begin
            n_fail++;
            $display("FAIL %s read_data_hold got=%h exp=%h", name, io_read_data, model_rd);
        end
        check_err(name);
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if ({io_ready, mmio_cs, mmio_read, mmio_write, err_valid} !== 5'b0 ||
            io_read_data !== 32'h0 || mmio_addr !== 21'h0 || mmio_wr_data !== 32'h0 ||
            err_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL %s outputs_zero got rdy=%b cs=%b rd=%b wr=%b ev=%b rdata=%h addr=%h wdata=%h ea=%h exp=all0",
                     name, io_ready, mmio_cs, mmio_read, mmio_write, err_valid,
                     io_read_data, mmio_addr, mmio_wr_data, err_addr);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        io_addr_strobe = 1'b0; io_read_strobe = 1'b0; io_write_strobe = 1'b0;
        io_address = 32'h0; io_write_data = 32'h0; io_byte_enable = 4'hF;
        mmio_rd_data = 32'h0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
    endtask

    task automatic test_write();
        access("write", 1'b1, 1'b0, 32'hC000_0014, 32'h1234_5678, 32'h0, 0, 1'b0);
        access("write_hi", 1'b1, 1'b0, 32'hC07F_FFFC, 32'hFFFF_0000, 32'h0, 0, 1'b0);
    endtask

    task automatic test_read();
        access("read", 1'b0, 1'b1, 32'hC000_0008, 32'h0, 32'hA5A5_0001, 0, 1'b0);
        access("write_keeps_rdata", 1'b1, 1'b0, 32'hC000_0020, 32'hCAFE_F00D, 32'h0, 0, 1'b0);
        access("read2", 1'b0, 1'b1, 32'hC012_3454, 32'h0, 32'h5A5A_7777, 0, 1'b0);
    endtask

    task automatic test_out_of_window();
        access("oow_read", 1'b0, 1'b1, 32'h8000_0000, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
        access("oow_write", 1'b1, 1'b0, 32'hC100_0000, 32'h1111_2222, 32'h0, 0, 1'b0);
    endtask

    task automatic test_ignored_strobes();
        access("strobe_in_wait", 1'b0, 1'b1, 32'hC000_0040, 32'h0, 32'h0BAD_F00D, 2, 1'b0);
        access("strobe_in_resp", 1'b1, 1'b0, 32'hC000_0044, 32'h7777_8888, 32'h0, 2, 1'b0);
    endtask

    task automatic test_dual_strobe();
        access("dual_strobe", 1'b1, 1'b1, 32'hC000_0030, 32'h3333_4444, 32'h9999_9999, 0, 1'b0);
    endtask

    task automatic test_err_clr();
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        model_ev = 1'b0;
        model_ea = 32'h0;
        @(negedge clk);
        check_err("err_clr");
        access("err_first", 1'b0, 1'b1, 32'h8000_0004, 32'h0, 32'h0, 0, 1'b0);
        access("err_sticky", 1'b0, 1'b1, 32'h4000_0008, 32'h0, 32'h0, 0, 1'b0);
        access("err_clr_vs_new", 1'b0, 1'b1, 32'h2000_000C, 32'h0, 32'h0, 0, 1'b1);
    endtask

    task automatic test_reset_mid();
        int rdy_n;
        int strobe_n;
        rdy_n = 0;
        strobe_n = 0;
        @(posedge clk); #1;
        io_addr_strobe = 1'b1; io_read_strobe = 1'b1; io_write_strobe = 1'b0;
        io_address = 32'hC000_0050; mmio_rd_data = 32'h1357_9BDF;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(posedge clk); #1;
            io_addr_strobe = 1'b0; io_read_strobe = 1'b0;
            reset = (cyc == 2);
            @(negedge clk);
            if (io_ready) rdy_n++;
            if (cyc >= 3 && (mmio_read || mmio_write || mmio_cs)) strobe_n++;
            if (cyc == 3) check_all_zero("reset_mid");
        end
        model_rd = 32'h0;
        model_ev = 1'b0;
        model_ea = 32'h0;
        n_checks++;
        if (rdy_n != 0 || strobe_n != 0) begin
            n_fail++;
            $display("FAIL reset_mid abort ready=%0d strobes=%0d exp=0/0", rdy_n, strobe_n);
        end
        access("read_after_reset", 1'b0, 1'b1, 32'hC000_0008, 32'h0, 32'h2468_ACE0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_out_of_window();
        test_ignored_strobes();
        test_dual_strobe();
        test_err_clr();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
